// File: rtl/regbank_wr_arbiter_if.sv
// Writeback request bus: NREQ packed valid/addr/data lanes with a one-hot ready grant.
// Requesters drive the master side and the arbiter sits on the slave side.
interface regbank_wr_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*4-1:0]  req_addr;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    modport master (output req_valid, output req_addr, output req_data, input req_ready);
    modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/regbank_wr_arbiter.sv
// Arbitrates NREQ writeback requesters onto the single register-bank write port (WE3/A3/WD3).
// Also drops writes to the protected register and publishes a pending-write mask for decode.
module regbank_wr_arbiter #(
    parameter int NREQ      = 3,
    parameter int PRIO0     = 1,
    parameter int PROT_ADDR = 14,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    regbank_wr_arbiter_if.slave req,
    input  logic                stall,
    input  logic                flush,
    output logic                WE3,
    output logic [3:0]          A3,
    output logic [31:0]         WD3,
    output logic [15:0]         pend_mask,
    output logic                drop_err,
    output logic [CNT_W-1:0]    wr_count
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gidx;
    logic [NREQ-1:0]  grant;
    logic             rr_grant;
    logic             xfer;
    logic [3:0]       sel_addr;
    logic [31:0]      sel_data;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        grant    = '0;
        gidx     = '0;
        rr_grant = 1'b0;
        if (rst && !stall) begin
            if (PRIO0 != 0 && req.req_valid[0]) begin
                grant[0] = 1'b1;
            end else if (|req.req_valid) begin
                // Lowest valid index is the wrap-around fallback; any valid index at or
                // after rr_ptr overrides it, lowest such index winning.
                for (int i = NREQ - 1; i >= 0; i--) begin
                    if (req.req_valid[i]) gidx = PTR_W'(i);
                end
                for (int i = NREQ - 1; i >= 0; i--) begin
                    if (req.req_valid[i] && i >= int'(rr_ptr)) gidx = PTR_W'(i);
                end
                grant[gidx] = 1'b1;
                rr_grant    = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | req.req_addr[4*i +: 4];
                sel_data = sel_data | req.req_data[32*i +: 32];
            end
        end
    end

    assign req.req_ready = grant;
    assign xfer          = |grant;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WE3       <= 1'b0;
            A3        <= '0;
            WD3       <= '0;
            pend_mask <= '0;
            drop_err  <= 1'b0;
        end else begin
            WE3       <= 1'b0;
            pend_mask <= '0;
            drop_err  <= 1'b0;
            // A flush on the transfer edge discards that write silently.
            if (xfer && !flush) begin
                if (sel_addr == 4'(PROT_ADDR)) begin
                    drop_err <= 1'b1;
                end else begin
                    WE3       <= 1'b1;
                    A3        <= sel_addr;
                    WD3       <= sel_data;
                    pend_mask <= 16'h0001 << sel_addr;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr   <= '0;
            wr_count <= '0;
        end else begin
            if (rr_grant) begin
                rr_ptr <= (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
            end
            if (WE3 && !flush && wr_count != '1) begin
                wr_count <= wr_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Bench for regbank_wr_arbiter: a priority instance driven from a vector table with a
// scoreboard of bank-port results, plus a round-robin/saturating instance for the sequences.
module tb_regbank_wr_arbiter;
    localparam int NREQ = 3;

    typedef struct {
        logic [2:0]  valid;
        logic [11:0] addr;
        logic [95:0] data;
        logic        stall;
        logic        flush;
        logic [2:0]  exp_ready;
    } vec_t;

    typedef struct {
        logic        we;
        logic [3:0]  a3;
        logic [31:0] wd3;
        logic        drop;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;

    logic        we3, drop;
    logic [3:0]  a3;
    logic [31:0] wd3;
    logic [15:0] pend;
    logic [15:0] cnt;

    logic        rr_we3, rr_drop;
    logic [3:0]  rr_a3;
    logic [31:0] rr_wd3;
    logic [15:0] rr_pend;
    logic [1:0]  rr_cnt;

    int   n_checks = 0;
    int   n_pass = 0;
    int   model_cnt = 0;
    exp_t sb[$];
    vec_t vecs[13];

    always #5 clk = ~clk;

    regbank_wr_arbiter_if #(.NREQ(NREQ)) bus ();
    regbank_wr_arbiter_if #(.NREQ(NREQ)) rr_bus ();

    assign rr_bus.req_valid = bus.req_valid;
    assign rr_bus.req_addr  = bus.req_addr;
    assign rr_bus.req_data  = bus.req_data;

    regbank_wr_arbiter #(.NREQ(NREQ), .PRIO0(1), .PROT_ADDR(14), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req(bus.slave), .stall(stall), .flush(flush),
        .WE3(we3), .A3(a3), .WD3(wd3), .pend_mask(pend), .drop_err(drop), .wr_count(cnt)
    );

    regbank_wr_arbiter #(.NREQ(NREQ), .PRIO0(0), .PROT_ADDR(14), .CNT_W(2)) dut_rr (
        .clk(clk), .rst(rst), .req(rr_bus.slave), .stall(stall), .flush(flush),
        .WE3(rr_we3), .A3(rr_a3), .WD3(rr_wd3), .pend_mask(rr_pend), .drop_err(rr_drop),
        .wr_count(rr_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [2:0] v, input logic [3:0] a0, a1, a2,
                                input logic [31:0] d0, d1, d2, input logic st, fl,
                                input logic [2:0] er);
        vec_t r;
        r.valid = v; r.addr = {a2, a1, a0}; r.data = {d2, d1, d0};
        r.stall = st; r.flush = fl; r.exp_ready = er;
        return r;
    endfunction

    task automatic drive_idle();
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        stall = 1'b0;
        flush = 1'b0;
    endtask

    // Leaves the bench at posedge+1 with the scoreboard primed for the idle reset state.
    task automatic do_reset();
        exp_t e;
        rst = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        e.we = 1'b0; e.a3 = '0; e.wd3 = '0; e.drop = 1'b0;
        sb.push_back(e);
        model_cnt = 0;
    endtask

    // One table cycle: drive at posedge+1, compare at posedge+4, queue next-cycle result.
    task automatic apply(input vec_t v, input int idx);
        exp_t        e, nx;
        logic [3:0]  ga;
        logic [31:0] gd;
        string       tag;
        tag = $sformatf("vec%0d", idx);
        bus.req_valid = v.valid;
        bus.req_addr  = v.addr;
        bus.req_data  = v.data;
        stall = v.stall;
        flush = v.flush;
        #3;
        check({tag, " ready"}, 32'(bus.req_ready), 32'(v.exp_ready));
        e.we = 1'b0; e.a3 = '0; e.wd3 = '0; e.drop = 1'b0;
        if (sb.size() != 0) e = sb.pop_front();
        check({tag, " WE3"}, 32'(we3), 32'(e.we));
        check({tag, " pend_mask"}, 32'(pend), e.we ? (32'd1 << e.a3) : 32'd0);
        check({tag, " drop_err"}, 32'(drop), 32'(e.drop));
        check({tag, " wr_count"}, 32'(cnt), 32'(model_cnt));
        if (e.we) begin
            check({tag, " A3"}, 32'(a3), 32'(e.a3));
            check({tag, " WD3"}, wd3, e.wd3);
        end
        ga = '0;
        gd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (v.exp_ready[i]) begin
                ga = v.addr[4*i +: 4];
                gd = v.data[32*i +: 32];
            end
        end
        nx.we   = (|v.exp_ready) && !v.flush && (ga != 4'd14);
        nx.drop = (|v.exp_ready) && !v.flush && (ga == 4'd14);
        nx.a3   = ga;
        nx.wd3  = gd;
        sb.push_back(nx);
        if (e.we && !v.flush) model_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] rr_exp;

        vecs[0]  = mk(3'b010, 0, 3, 0, 0, 32'hDEADBEEF, 0, 0, 0, 3'b010);
        vecs[1]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        vecs[2]  = mk(3'b100, 0, 0, 14, 0, 0, 32'h1111_2222, 0, 0, 3'b100);
        vecs[3]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        vecs[4]  = mk(3'b011, 5, 6, 0, 32'hA5A5_0005, 32'h5A5A_0006, 0, 0, 0, 3'b001);
        vecs[5]  = mk(3'b011, 5, 6, 0, 32'hA5A5_1005, 32'h5A5A_0006, 0, 0, 0, 3'b001);
        vecs[6]  = mk(3'b010, 0, 6, 0, 0, 32'h5A5A_0006, 0, 0, 0, 3'b010);
        vecs[7]  = mk(3'b111, 1, 2, 3, 32'h1, 32'h2, 32'h3, 1, 0, 3'b000);
        vecs[8]  = mk(3'b110, 0, 8, 9, 0, 32'h0808_0808, 32'h0909_0909, 0, 1, 3'b100);
        vecs[9]  = mk(3'b100, 0, 0, 15, 0, 0, 32'hCAFE_F00D, 0, 0, 3'b100);
        vecs[10] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000);
        vecs[11] = mk(3'b001, 14, 0, 0, 32'h7777_7777, 0, 0, 0, 1, 3'b001);
        vecs[12] = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);

        // Outputs and grants while reset is held, with every requester valid.
        drive_idle();
        bus.req_valid = 3'b111;
        #2;
        check("reset ready", 32'(bus.req_ready), 32'd0);
        check("reset WE3", 32'(we3), 32'd0);
        check("reset pend_mask", 32'(pend), 32'd0);
        check("reset wr_count", 32'(cnt), 32'd0);

        // Round-robin instance: strict rotation over all valid, then saturating count.
        do_reset();
        bus.req_valid = 3'b111;
        bus.req_addr  = {4'd4, 4'd2, 4'd1};
        bus.req_data  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        for (int k = 0; k < 6; k++) begin
            #3;
            rr_exp = 3'b001 << (k % 3);
            check($sformatf("rr grant %0d", k), 32'(rr_bus.req_ready), 32'(rr_exp));
            @(posedge clk);
            #1;
        end
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        check("rr wr_count saturated", 32'(rr_cnt), 32'd3);

        // Priority instance: vector table against the scoreboard.
        do_reset();
        foreach (vecs[i]) apply(vecs[i], i);

        // Asynchronous reset mid-cycle while a write is presented on the port.
        bus.req_valid = 3'b010;
        bus.req_addr  = {4'd0, 4'd7, 4'd0};
        bus.req_data  = {32'h0, 32'h0707_0707, 32'h0};
        @(posedge clk);
        #1;
        check("pre-reset WE3", 32'(we3), 32'd1);
        check("pre-reset wr_count", 32'(cnt), 32'(model_cnt));
        bus.req_valid = 3'b111;
        #2;
        rst = 1'b0;
        #1;
        check("async WE3", 32'(we3), 32'd0);
        check("async pend_mask", 32'(pend), 32'd0);
        check("async wr_count", 32'(cnt), 32'd0);
        check("async ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk) rst = 1'b1;
        #1;
        check("post-reset rr first grant", 32'(rr_bus.req_ready), 32'b001);
        check("post-reset prio first grant", 32'(bus.req_ready), 32'b001);

        drive_idle();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
